// File: rtl/sd_stream_pkg.sv
// Shared definitions for the SD stream sequencer: FSM state encodings,
// error codes, status bit positions and output buffer depth.
package sd_stream_pkg;

   typedef enum logic [4:0] {
      StIdle     = 5'd0,
      StInit     = 5'd1,
      StWaitInit = 5'd2,
      StRead     = 5'd3,
      StWaitRead = 5'd4,
      StNext     = 5'd5,
      StDrain    = 5'd6,
      StDone     = 5'd7,
      StError    = 5'd31
   } state_e;

   localparam logic [2:0] ErrNone    = 3'd0;
   localparam logic [2:0] ErrInit    = 3'd1;
   localparam logic [2:0] ErrTimeout = 3'd2;
   localparam logic [2:0] ErrRetry   = 3'd3;
   localparam logic [2:0] ErrData    = 3'd4;

   localparam int unsigned StatusErrBit  = 7;
   localparam int unsigned StatusDoneBit = 6;
   localparam int unsigned StatusBusyBit = 5;

   localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/sd_stream_skid.sv
// Two-entry valid/ready byte buffer with synchronous flush. Head entry drives
// the output; the tail entry absorbs one byte while the consumer stalls.
module sd_stream_skid
   import sd_stream_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       flush_i,
   input  logic       in_valid_i,
   input  logic [7:0] in_data_i,
   output logic       in_ready_o,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   input  logic       out_ready_i,
   output logic       empty_o
);

   logic [1:0] count_q, count_d;
   logic [7:0] head_q, head_d;
   logic [7:0] tail_q, tail_d;
   logic       push, pop;

   assign in_ready_o  = (count_q != 2'(SkidDepth));
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;
   assign empty_o     = (count_q == 2'd0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   // Next-state of the two entries for push, pop, both, or flush.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = in_data_i;
               else                 tail_d = in_data_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = in_data_i;
               end else begin
                  head_d = tail_q;
                  tail_d = in_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Entry storage and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= 2'd0;
         head_q  <= 8'h00;
         tail_q  <= 8'h00;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/sd_stream_sequencer.sv
// SD multi-block read sequencer: card init, per-block read with retry,
// byte-count checking, and a skid-buffered byte output stream.
// Optional: define SD_STREAM_CHECKSUM_EN for a running 16-bit output checksum.
module sd_stream_sequencer
   import sd_stream_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned BLOCK_BYTES  = 512,
   parameter int unsigned ADDR_MODE    = 0,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned INIT_TIMEOUT = 65535
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [CNT_WIDTH-1:0]  block_count_i,
   output logic                  init_start_o,
   input  logic                  init_ready_i,
   input  logic                  init_error_i,
   output logic                  rd_start_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [7:0]            rd_byte_i,
   input  logic                  rd_byte_valid_i,
   output logic                  rd_byte_ready_o,
   input  logic                  rd_done_i,
   input  logic                  rd_error_i,
   output logic [7:0]            out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [2:0]            error_code_o,
   output logic [7:0]            status_o,
   output logic [15:0]           checksum_o
);

   localparam int unsigned BcW = $clog2(BLOCK_BYTES + 2);
   localparam int unsigned RtW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int unsigned ToW = (INIT_TIMEOUT < 2) ? 1 : $clog2(INIT_TIMEOUT + 1);
   localparam logic [BcW-1:0] BlockBytesC  = BcW'(BLOCK_BYTES);
   localparam logic [BcW-1:0] ByteSatC     = BcW'(BLOCK_BYTES + 1);
   localparam logic [RtW-1:0] MaxRetryC    = RtW'(MAX_RETRY);
   localparam logic [ToW-1:0] TimeoutLastC = ToW'(INIT_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] AddrStepC =
      (ADDR_MODE != 0) ? ADDR_WIDTH'(BLOCK_BYTES) : ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_WIDTH-1:0]  blk_left_q, blk_left_d;
   logic [BcW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [RtW-1:0]        retry_q, retry_d;
   logic [ToW-1:0]        timeout_q, timeout_d;
   logic [2:0]            err_q, err_d;
   logic                  flush, push_ready, skid_empty, byte_accept, idle_like;

   assign idle_like       = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
   assign rd_byte_ready_o = (state_q == StWaitRead) && push_ready;
   assign byte_accept     = rd_byte_valid_i && rd_byte_ready_o;

   // Sequencer next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rd_addr_d  = rd_addr_q;
      blk_left_d = blk_left_q;
      byte_cnt_d = byte_cnt_q;
      retry_d    = retry_q;
      timeout_d  = timeout_q;
      err_d      = err_q;
      flush      = 1'b0;
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start_i) begin
               cur_addr_d = start_addr_i;
               blk_left_d = block_count_i;
               err_d      = ErrNone;
               retry_d    = '0;
               byte_cnt_d = '0;
               timeout_d  = '0;
               state_d    = (block_count_i == '0) ? StDone : StInit;
            end
         end
         StInit: begin
            timeout_d = '0;
            state_d   = StWaitInit;
         end
         StWaitInit: begin
            if (init_error_i) begin
               err_d   = ErrInit;
               state_d = StError;
            end else if (init_ready_i) begin
               state_d = StRead;
            end else if (timeout_q >= TimeoutLastC) begin
               err_d   = ErrTimeout;
               state_d = StError;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         StRead: begin
            byte_cnt_d = '0;
            state_d    = StWaitRead;
         end
         StWaitRead: begin
            if (byte_accept && (byte_cnt_q != ByteSatC)) byte_cnt_d = byte_cnt_q + 1'b1;
            // The byte accepted alongside rd_done counts toward the block.
            if (rd_done_i) begin
               if (rd_error_i && (byte_cnt_d == '0)) begin
                  if (retry_q < MaxRetryC) begin
                     retry_d = retry_q + 1'b1;
                     state_d = StRead;
                  end else begin
                     err_d   = ErrRetry;
                     state_d = StError;
                  end
               end else if (rd_error_i || (byte_cnt_d != BlockBytesC)) begin
                  err_d   = ErrData;
                  state_d = StError;
               end else begin
                  state_d = StNext;
               end
            end
         end
         StNext: begin
            blk_left_d = blk_left_q - 1'b1;
            cur_addr_d = cur_addr_q + AddrStepC;
            retry_d    = '0;
            state_d    = (blk_left_q == CNT_WIDTH'(1)) ? StDrain : StRead;
         end
         StDrain: begin
            if (skid_empty) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StRead) rd_addr_d = cur_addr_d;
      if ((state_d == StError) && (state_q != StError)) flush = 1'b1;
   end

   // State and datapath registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         cur_addr_q <= '0;
         rd_addr_q  <= '0;
         blk_left_q <= '0;
         byte_cnt_q <= '0;
         retry_q    <= '0;
         timeout_q  <= '0;
         err_q      <= ErrNone;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rd_addr_q  <= rd_addr_d;
         blk_left_q <= blk_left_d;
         byte_cnt_q <= byte_cnt_d;
         retry_q    <= retry_d;
         timeout_q  <= timeout_d;
         err_q      <= err_d;
      end
   end

   sd_stream_skid u_skid (
      .clk_i       (clock_i),
      .rst_i       (reset_i),
      .flush_i     (flush),
      .in_valid_i  (rd_byte_valid_i && (state_q == StWaitRead)),
      .in_data_i   (rd_byte_i),
      .in_ready_o  (push_ready),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .empty_o     (skid_empty)
   );

   assign init_start_o = (state_q == StInit);
   assign rd_start_o   = (state_q == StRead);
   assign rd_addr_o    = rd_addr_q;
   assign busy_o       = !idle_like;
   assign done_o       = (state_q == StDone);
   assign error_o      = (state_q == StError);
   assign error_code_o = err_q;

   // LED status word.
   always_comb begin
      status_o                = 8'h00;
      status_o[4:0]           = state_q;
      status_o[StatusBusyBit] = busy_o;
      status_o[StatusDoneBit] = done_o;
      status_o[StatusErrBit]  = error_o;
   end

`ifdef SD_STREAM_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   // Running sum of emitted bytes; cleared on start, frozen in DONE/ERROR.
   always_comb begin
      csum_d = csum_q;
      if (idle_like && start_i) begin
         csum_d = 16'h0000;
      end else if (out_valid_o && out_ready_i && (state_q != StDone) && (state_q != StError)) begin
         csum_d = csum_q + {8'h00, out_data_o};
      end
   end

   // Checksum register.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) csum_q <= 16'h0000;
      else         csum_q <= csum_d;
   end

   assign checksum_o = csum_q;
`else
   assign checksum_o = 16'h0000;
`endif

endmodule
